// File: rtl/fs_sync_if.sv
// Frame-clock monitor bus: external fs_in toward the monitor, alignment/lock status back out.
interface fs_sync_if #(
    parameter int W = 10
);
    logic         fs_in;
    logic         fs_strobe;
    logic [7:0]   phase;
    logic [W-1:0] period;
    logic         period_valid;
    logic         locked;
    logic [7:0]   glitch_count;

    modport master (
        output fs_in,
        input  fs_strobe, phase, period, period_valid, locked, glitch_count
    );
    modport slave (
        input  fs_in,
        output fs_strobe, phase, period, period_valid, locked, glitch_count
    );
endinterface

// File: rtl/fs_sync_monitor.sv
// Synchronizes an external frame clock into clk_256fs, measures its period
// and tracks lock once consecutive periods sit within NOMINAL +/- TOL.
module fs_sync_monitor #(
    parameter int NOMINAL    = 256,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int W          = 10
) (
    input  logic     clk_256fs,
    input  logic     rst,
    fs_sync_if.slave bus
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0]  CNT_MAX  = '1;
    localparam logic [W-1:0]  P_LO     = W'(NOMINAL - TOL);
    localparam logic [W-1:0]  P_HI     = W'(NOMINAL + TOL);
    localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

    state_e        state_q, state_d;
    logic [2:0]    sync_q;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [W-1:0]  period_q, period_d;
    logic          pv_q, pv_d;
    logic          strobe_q;
    logic [7:0]    glitch_q, glitch_d;

    logic          edge_w, timeout_w, p_good, glitch_inc;
    logic [W-1:0]  p;

    // sync_q[0..2] are s1..s3; the edge is taken after two flops of settling
    assign edge_w    = sync_q[1] & ~sync_q[2];
    assign p         = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + W'(1);
    assign p_good    = (p >= P_LO) && (p <= P_HI);
    assign timeout_w = ~edge_w && (cnt_q == P_HI);

    always_ff @(posedge clk_256fs or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            state_q  <= SEARCH;
            good_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            strobe_q <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync_q   <= {sync_q[1:0], bus.fs_in};
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            good_q   <= good_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            strobe_q <= edge_w;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        period_d   = period_q;
        pv_d       = 1'b0;
        glitch_inc = 1'b0;
        if (edge_w)                cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + W'(1);

        case (state_q)
            SEARCH: begin
                // first edge only establishes the reference; nothing to measure yet
                if (edge_w) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (edge_w) begin
                    period_d = p;
                    pv_d     = 1'b1;
                    if (p_good) begin
                        good_d = good_q + GW'(1);
                        if (good_d == GOOD_TGT) state_d = LOCKED;
                    end else begin
                        good_d     = '0;
                        glitch_inc = 1'b1;
                    end
                end else if (timeout_w) begin
                    good_d     = '0;
                    glitch_inc = 1'b1;
                    state_d    = SEARCH;
                end
            end
            LOCKED: begin
                if (edge_w) begin
                    period_d = p;
                    pv_d     = 1'b1;
                    if (!p_good) begin
                        good_d     = '0;
                        glitch_inc = 1'b1;
                        state_d    = ACQUIRE;
                    end
                end else if (timeout_w) begin
                    glitch_inc = 1'b1;
                    state_d    = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase

        glitch_d = (glitch_inc && glitch_q != 8'hFF) ? glitch_q + 8'd1 : glitch_q;
    end

    assign bus.fs_strobe    = strobe_q;
    assign bus.phase        = cnt_q[7:0];
    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.locked       = (state_q == LOCKED);
    assign bus.glitch_count = glitch_q;
endmodule

// File: tb/tb_fs_sync_monitor.sv
// Directed bench for fs_sync_monitor: lock, tolerance, timeout, glitch, reset and saturation.
module tb_fs_sync_monitor;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fs_sync_if #(.W(10)) bus ();

    fs_sync_monitor #(.NOMINAL(256), .TOL(2), .LOCK_COUNT(4), .W(10)) dut (
        .clk_256fs (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         off;
        int         nstb;
        int         npv;
        logic [9:0] per;
        logic       lk;
        logic [7:0] gc;
        logic [7:0] ph;
        logic [7:0] ph_pre;
    } obs_t;

    // One fs_in rise followed by p cycles (high for p/2). The strobe seen in this
    // window belongs to this rise and reports the interval of the previous call.
    task automatic drive_rise(input int p, output obs_t o);
        o.off = -1; o.nstb = 0; o.npv = 0; o.per = '0;
        o.lk = 1'b0; o.gc = '0; o.ph = '0; o.ph_pre = '0;
        bus.fs_in = 1'b1;
        for (int i = 1; i <= p; i++) begin
            @(negedge clk);
            if (i == 2) o.ph_pre = bus.phase;
            if (bus.period_valid) o.npv++;
            if (bus.fs_strobe) begin
                o.nstb++;
                if (o.off < 0) begin
                    o.off = i; o.per = bus.period; o.lk = bus.locked;
                    o.gc = bus.glitch_count; o.ph = bus.phase;
                end
            end
            if (i == p / 2) bus.fs_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fs_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.fs_strobe, bus.period_valid, bus.locked} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {bus.fs_strobe, bus.period_valid, bus.locked});
        end
        checks++;
        if ({bus.phase, bus.period, bus.glitch_count} !== 26'd0) begin
            errors++; $display("FAIL reset_values: got phase %0d period %0d glitch %0d expected 0", bus.phase, bus.period, bus.glitch_count);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_lock();
        obs_t o;
        for (int c = 1; c <= 5; c++) begin
            drive_rise(256, o);
            checks++;
            if (o.off !== 3 || o.nstb !== 1) begin
                errors++; $display("FAIL lock_strobe%0d: got offset %0d count %0d expected 3 1", c, o.off, o.nstb);
            end
            checks++;
            if (o.npv !== ((c == 1) ? 0 : 1)) begin
                errors++; $display("FAIL lock_pv%0d: got %0d expected %0d", c, o.npv, (c == 1) ? 0 : 1);
            end
            checks++;
            if (o.lk !== (c == 5)) begin
                errors++; $display("FAIL lock_locked%0d: got %b expected %b", c, o.lk, (c == 5));
            end
            if (c >= 2) begin
                checks++;
                if (o.per !== 10'd256 || o.ph !== 8'd0 || o.ph_pre !== 8'd255 || o.gc !== 8'd0) begin
                    errors++; $display("FAIL lock_meas%0d: got period %0d phase %0d pre %0d glitch %0d expected 256 0 255 0", c, o.per, o.ph, o.ph_pre, o.gc);
                end
            end
        end
    endtask

    task automatic test_tolerance();
        obs_t o;
        int   lens [9] = '{254, 258, 259, 256, 256, 256, 256, 256, 256};
        logic [9:0] exp_per [9] = '{10'd256, 10'd254, 10'd258, 10'd259, 10'd256, 10'd256, 10'd256, 10'd256, 10'd256};
        logic exp_lk [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        for (int c = 0; c < 9; c++) begin
            drive_rise(lens[c], o);
            checks++;
            if (o.per !== exp_per[c] || o.lk !== exp_lk[c] || o.npv !== 1) begin
                errors++; $display("FAIL tol_step%0d: got period %0d locked %b pv %0d expected %0d %b 1", c, o.per, o.lk, o.npv, exp_per[c], exp_lk[c]);
            end
            checks++;
            if (o.gc !== ((c >= 3) ? 8'd1 : 8'd0)) begin
                errors++; $display("FAIL tol_glitch%0d: got %0d expected %0d", c, o.gc, (c >= 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        int   fall = -1;
        int   npv = 0;
        int   nstb = 0;
        logic [7:0] gc_at = '0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.period_valid) npv++;
            if (bus.fs_strobe) nstb++;
            if (fall < 0 && !bus.locked) begin
                fall = i; gc_at = bus.glitch_count;
            end
        end
        // last strobe was 3 cycles into a 256-cycle window
        checks++;
        if (fall + 256 - 3 !== 259) begin
            errors++; $display("FAIL timeout_fall: got %0d cycles after strobe expected 259", fall + 256 - 3);
        end
        checks++;
        if (gc_at !== 8'd2 || npv !== 0 || nstb !== 0) begin
            errors++; $display("FAIL timeout_side: got glitch %0d pv %0d strobes %0d expected 2 0 0", gc_at, npv, nstb);
        end
        for (int c = 1; c <= 5; c++) begin
            drive_rise(256, o);
            checks++;
            if (o.lk !== (c == 5) || o.npv !== ((c == 1) ? 0 : 1) || o.off !== 3) begin
                errors++; $display("FAIL relock%0d: got locked %b pv %0d offset %0d expected %b %0d 3", c, o.lk, o.npv, o.off, (c == 5), (c == 1) ? 0 : 1);
            end
        end
    endtask

    task automatic test_glitch();
        obs_t o;
        int   lens [7] = '{100, 156, 256, 256, 256, 256, 256};
        logic [9:0] exp_per [7] = '{10'd256, 10'd100, 10'd156, 10'd256, 10'd256, 10'd256, 10'd256};
        logic exp_lk [7] = '{1, 0, 0, 0, 0, 0, 1};
        logic [7:0] exp_gc [7] = '{8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
        for (int c = 0; c < 7; c++) begin
            drive_rise(lens[c], o);
            checks++;
            if (o.per !== exp_per[c] || o.lk !== exp_lk[c] || o.gc !== exp_gc[c]) begin
                errors++; $display("FAIL glitch_step%0d: got period %0d locked %b glitch %0d expected %0d %b %0d", c, o.per, o.lk, o.gc, exp_per[c], exp_lk[c], exp_gc[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nstb = 0;
        int npv = 0;
        int nlk = 0;
        bus.fs_in = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got locked %b expected 1", bus.locked);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.fs_strobe, bus.period_valid, bus.locked, bus.phase, bus.period, bus.glitch_count} !== 29'd0) begin
            errors++; $display("FAIL rstmid_async: got locked %b phase %0d period %0d glitch %0d expected all 0", bus.locked, bus.phase, bus.period, bus.glitch_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.fs_strobe) nstb++;
            if (bus.period_valid) npv++;
            if (bus.locked) nlk++;
        end
        checks++;
        if (nstb !== 1 || npv !== 0 || nlk !== 0) begin
            errors++; $display("FAIL rstmid_release: got strobes %0d pv %0d locked %0d expected 1 0 0", nstb, npv, nlk);
        end
    endtask

    task automatic test_saturate();
        obs_t o;
        int   nlk = 0;
        bus.fs_in = 1'b0;
        repeat (10) @(negedge clk);
        for (int c = 1; c <= 300; c++) begin
            drive_rise(128, o);
            if (o.lk) nlk++;
            if (c == 10 || c == 254 || c == 255) begin
                checks++;
                if (o.gc !== 8'(c)) begin
                    errors++; $display("FAIL sat_glitch%0d: got %0d expected %0d", c, o.gc, c);
                end
            end
        end
        checks++;
        if (o.gc !== 8'd255 || o.per !== 10'd128) begin
            errors++; $display("FAIL sat_final: got glitch %0d period %0d expected 255 128", o.gc, o.per);
        end
        checks++;
        if (nlk !== 0) begin
            errors++; $display("FAIL sat_locked: got %0d locked strobes expected 0", nlk);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.fs_in = 1'b0;
        test_reset();
        test_lock();
        test_tolerance();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
